// File: rtl/bc_pkg.sv
// bc_pkg: BC memory layout shared by the pyramid builder and the level reader.
// Holds default geometry, derived widths, the reader FSM states and address helpers.
package bc_pkg;

    localparam int BC_BOX_IDX  = 3;
    localparam int BC_DATA_LEN = 8;
    localparam int BC_ADDR_W   = 2 * BC_BOX_IDX + 1;
    localparam int SUM_W       = BC_DATA_LEN + 2 * BC_BOX_IDX;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_OUT,
        ST_FIN
    } rd_state_e;

    // First row of level k inside bank 1; levels are packed upward.
    function automatic int unsigned y_off(
        input int unsigned b,
        input int unsigned level
    );
        if (level == 32'd0) begin
            return 32'd0;
        end
        return (32'd1 << b) - (32'd1 << (b - level + 32'd1));
    endfunction

    // Address = {xa, bank, ya}; level 0 lives in bank 0, all others in bank 1.
    function automatic int unsigned bc_addr(
        input int unsigned b,
        input int unsigned level,
        input int unsigned xa,
        input int unsigned ya
    );
        int unsigned bank;
        bank = (level == 32'd0) ? 32'd0 : 32'd1;
        return (xa << (b + 32'd1)) | (bank << b) | ya;
    endfunction

endpackage

// File: rtl/bc_level_reader_if.sv
// bc_level_reader_if: per-level record stream (valid/ready) out of the reader.
// master drives lvl_valid/lvl_idx/lvl_sum/lvl_nz and takes lvl_ready; slave is the consumer.
interface bc_level_reader_if #(
    parameter int BOX_IDX  = 3,
    parameter int DATA_LEN = 8
);
    logic                          lvl_valid;
    logic                          lvl_ready;
    logic [BOX_IDX:0]              lvl_idx;
    logic [DATA_LEN+2*BOX_IDX-1:0] lvl_sum;
    logic [2*BOX_IDX:0]            lvl_nz;

    modport master (
        output lvl_valid,
        output lvl_idx,
        output lvl_sum,
        output lvl_nz,
        input  lvl_ready
    );

    modport slave (
        input  lvl_valid,
        input  lvl_idx,
        input  lvl_sum,
        input  lvl_nz,
        output lvl_ready
    );
endinterface

// File: rtl/bc_scan_addr_gen.sv
// bc_scan_addr_gen: walks every box of one pyramid level, ya-offset outer, xa inner.
// Ports: clk, rst_n, step (scan active), level in; BC_rd_addr, rd_en, last_addr out.
module bc_scan_addr_gen
    import bc_pkg::*;
#(
    parameter int BOX_IDX = 3,
    parameter int LVL_W   = BOX_IDX + 1,
    parameter int ADDR_W  = 2 * BOX_IDX + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic [LVL_W-1:0]  level,
    output logic [ADDR_W-1:0] BC_rd_addr,
    output logic              rd_en,
    output logic              last_addr
);

    logic [BOX_IDX-1:0] xa_q, xa_d;
    logic [BOX_IDX-1:0] j_q, j_d;
    logic [BOX_IDX-1:0] side_m1;
    int unsigned        side;
    int unsigned        ya;

    always_comb begin
        side      = 32'd1 << (BOX_IDX - 32'(level));
        side_m1   = BOX_IDX'(side - 32'd1);
        last_addr = step && (xa_q == side_m1) && (j_q == side_m1);
        rd_en     = step;
        ya        = y_off(BOX_IDX, 32'(level)) + 32'(j_q);
        BC_rd_addr = '0;
        if (step) begin
            BC_rd_addr = ADDR_W'(bc_addr(BOX_IDX, 32'(level),
                                         32'(xa_q), ya));
        end
        // Counters idle at zero so every level starts at its origin.
        xa_d = '0;
        j_d  = '0;
        if (step && !last_addr) begin
            if (xa_q == side_m1) begin
                j_d = j_q + 1'b1;
            end else begin
                xa_d = xa_q + 1'b1;
                j_d  = j_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xa_q <= '0;
            j_q  <= '0;
        end else begin
            xa_q <= xa_d;
            j_q  <= j_d;
        end
    end

endmodule

// File: rtl/bc_level_reader.sv
// bc_level_reader: scans BC pyramid levels 0..MAX_BOX and emits (sum, nonzero) per level.
// Ports: CLK, RST_N, BC_mode, start; BC read bus (BC_rd_addr, rd_en, x); lvl record if; busy, done.
module bc_level_reader
    import bc_pkg::*;
#(
    parameter int BOX_IDX  = BC_BOX_IDX,
    parameter int MAX_BOX  = BC_BOX_IDX,
    parameter int DATA_LEN = BC_DATA_LEN
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  BC_mode,
    input  logic                  start,
    output logic [2*BOX_IDX:0]    BC_rd_addr,
    output logic                  rd_en,
    input  logic [DATA_LEN-1:0]   x,
    bc_level_reader_if.master     lvl,
    output logic                  busy,
    output logic                  done
);

    localparam int LVL_W = BOX_IDX + 1;
    localparam int S_W   = DATA_LEN + 2 * BOX_IDX;
    localparam int NZ_W  = 2 * BOX_IDX + 1;

    rd_state_e        state_q, state_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             dv_q;
    logic [S_W-1:0]   acc_sum_q, acc_sum_d;
    logic [NZ_W-1:0]  acc_nz_q, acc_nz_d;
    logic             valid_q, valid_d;
    logic [LVL_W-1:0] idx_q, idx_d;
    logic [S_W-1:0]   sum_q, sum_d;
    logic [NZ_W-1:0]  nz_q, nz_d;
    logic             step;
    logic             last_addr;
    logic             active;

    assign step   = (state_q == ST_SCAN);
    assign active = (state_q == ST_SCAN) || (state_q == ST_DRAIN) ||
                    (state_q == ST_OUT);

    bc_scan_addr_gen #(
        .BOX_IDX (BOX_IDX),
        .LVL_W   (LVL_W),
        .ADDR_W  (NZ_W)
    ) u_addr (
        .clk        (CLK),
        .rst_n      (RST_N),
        .step       (step),
        .level      (lvl_q),
        .BC_rd_addr (BC_rd_addr),
        .rd_en      (rd_en),
        .last_addr  (last_addr)
    );

    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        acc_sum_d = acc_sum_q;
        acc_nz_d  = acc_nz_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        nz_d      = nz_q;

        // x carries the word requested by the previous cycle's rd_en.
        if (dv_q) begin
            acc_sum_d = acc_sum_q + S_W'(x);
            acc_nz_d  = acc_nz_q + NZ_W'(x != '0);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start && !BC_mode) begin
                    state_d = ST_SCAN;
                    lvl_d   = '0;
                end
            end
            ST_SCAN: begin
                if (last_addr) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Last word has been folded in once the delay line empties.
                if (!dv_q) begin
                    state_d = ST_OUT;
                    valid_d = 1'b1;
                    idx_d   = lvl_q;
                    sum_d   = acc_sum_q;
                    nz_d    = acc_nz_q;
                end
            end
            ST_OUT: begin
                if (lvl.lvl_ready) begin
                    valid_d = 1'b0;
                    if (lvl_q == LVL_W'(MAX_BOX)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_SCAN;
                        lvl_d   = lvl_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (BC_mode && active) begin
            state_d = ST_IDLE;
        end

        if ((state_d == ST_SCAN) && (state_q != ST_SCAN)) begin
            acc_sum_d = '0;
            acc_nz_d  = '0;
        end

        if (state_d == ST_IDLE) begin
            valid_d = 1'b0;
            idx_d   = '0;
            sum_d   = '0;
            nz_d    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            lvl_q     <= '0;
            dv_q      <= 1'b0;
            acc_sum_q <= '0;
            acc_nz_q  <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            sum_q     <= '0;
            nz_q      <= '0;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            dv_q      <= rd_en;
            acc_sum_q <= acc_sum_d;
            acc_nz_q  <= acc_nz_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            nz_q      <= nz_d;
        end
    end

    assign lvl.lvl_valid = valid_q;
    assign lvl.lvl_idx   = idx_q;
    assign lvl.lvl_sum   = sum_q;
    assign lvl.lvl_nz    = nz_q;
    assign busy          = active;
    assign done          = (state_q == ST_FIN);

endmodule

// File: tb/tb_bc_level_reader.sv
// tb_bc_level_reader: randomized pyramid contents checked against a box-sum model.
// Memory model answers reads one cycle late; records, latency and addresses are checked.
module tb_bc_level_reader;

    localparam int B  = 3;
    localparam int MB = 3;
    localparam int DL = 8;
    localparam int AW = 2 * B + 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          BC_mode = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] BC_rd_addr;
    logic          rd_en;
    logic [DL-1:0] x;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [128];
    int unsigned exp_addr [$];
    bit          mon_en = 1'b0;

    bc_level_reader_if #(.BOX_IDX(B), .DATA_LEN(DL)) lvl ();

    bc_level_reader #(
        .BOX_IDX  (B),
        .MAX_BOX  (MB),
        .DATA_LEN (DL)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .BC_mode    (BC_mode),
        .start      (start),
        .BC_rd_addr (BC_rd_addr),
        .rd_en      (rd_en),
        .x          (x),
        .lvl        (lvl),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        x <= rd_en ? mem[BC_rd_addr] : DL'($urandom);
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bank-1 rows: each level sits just above the rows of the previous levels.
    function automatic int yoff(input int k);
        int r;
        r = 0;
        for (int i = 1; i < k; i++) r += 2 ** (B - i);
        return r;
    endfunction

    function automatic int addr_of(input int k, input int xa, input int j);
        return xa * (2 ** (B + 1)) + ((k > 0) ? 2 ** B : 0) + yoff(k) + j;
    endfunction

    // mode 0: level0 all v; 1: single 1 at (5,2); 2: random 0..v; 3: every word v
    task automatic fill(input int mode, input int v);
        int s;
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
        if (mode == 3) begin
            for (int a = 0; a < 128; a++) mem[a] = 8'(v);
            return;
        end
        for (int xa = 0; xa < 2 ** B; xa++)
            for (int j = 0; j < 2 ** B; j++) begin
                if (mode == 0) mem[addr_of(0, xa, j)] = 8'(v);
                else if (mode == 1) mem[addr_of(0, xa, j)] = 8'((xa == 5 && j == 2) ? 1 : 0);
                else mem[addr_of(0, xa, j)] = 8'($urandom_range(0, v));
            end
        for (int k = 1; k <= MB; k++)
            for (int xa = 0; xa < 2 ** (B - k); xa++)
                for (int j = 0; j < 2 ** (B - k); j++) begin
                    s = 0;
                    for (int d = 0; d < 4; d++)
                        s += int'(mem[addr_of(k - 1, 2 * xa + d / 2, 2 * j + d % 2)]);
                    mem[addr_of(k, xa, j)] = 8'((s > 255) ? 255 : s);
                end
    endtask

    task automatic exp_rec(input int k, output longint s, output longint nz);
        int v;
        s  = 0;
        nz = 0;
        for (int j = 0; j < 2 ** (B - k); j++)
            for (int xa = 0; xa < 2 ** (B - k); xa++) begin
                v = int'(mem[addr_of(k, xa, j)]);
                s += v;
                if (v != 0) nz++;
            end
    endtask

    always @(negedge CLK) begin
        if (mon_en && rd_en) begin
            if (exp_addr.size() == 0) chk("addr_extra", rd_en, 0);
            else chk("addr", BC_rd_addr, exp_addr.pop_front());
        end
    end

    // hold_lvl: level whose record is back-pressured for hold_n cycles.
    // inj_at: cycle of level 1 at which a stray start pulse is applied (0 = none).
    task automatic run_scan(input int hold_lvl, input int hold_n, input int inj_at);
        longint es;
        longint en;
        int     cyc;
        int     n;
        exp_addr.delete();
        for (int k = 0; k <= MB; k++)
            for (int j = 0; j < 2 ** (B - k); j++)
                for (int xa = 0; xa < 2 ** (B - k); xa++)
                    exp_addr.push_back(addr_of(k, xa, j));
        mon_en = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("busy_scan", busy, 1);
        for (int k = 0; k <= MB; k++) begin
            n = 4 ** (B - k);
            cyc = 0;
            lvl.lvl_ready = (k != hold_lvl);
            while (!lvl.lvl_valid && cyc < 300) begin
                @(negedge CLK);
                cyc++;
                start = (k == 1 && inj_at != 0 && cyc == inj_at);
            end
            start = 1'b0;
            chk("latency", cyc, n + 2);
            exp_rec(k, es, en);
            chk("idx", lvl.lvl_idx, k);
            chk("sum", lvl.lvl_sum, es);
            chk("nz", lvl.lvl_nz, en);
            if (!lvl.lvl_ready) begin
                for (int i = 0; i < hold_n; i++) begin
                    @(negedge CLK);
                    chk("hold_valid", lvl.lvl_valid, 1);
                    chk("hold_sum", lvl.lvl_sum, es);
                    chk("hold_rd", rd_en, 0);
                end
                lvl.lvl_ready = 1'b1;
            end
            @(negedge CLK);
            if (k < MB) begin
                chk("resume_rd", rd_en, 1);
            end else begin
                chk("done", done, 1);
                chk("busy_fin", busy, 0);
                chk("valid_fin", lvl.lvl_valid, 0);
            end
        end
        @(negedge CLK);
        chk("done_pulse", done, 0);
        chk("addr_left", exp_addr.size(), 0);
        mon_en = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd"}, rd_en, 0);
        chk({tag, "_addr"}, BC_rd_addr, 0);
        chk({tag, "_valid"}, lvl.lvl_valid, 0);
        chk({tag, "_idx"}, lvl.lvl_idx, 0);
        chk({tag, "_sum"}, lvl.lvl_sum, 0);
        chk({tag, "_nz"}, lvl.lvl_nz, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        lvl.lvl_ready = 1'b0;
        for (int a = 0; a < 128; a++) mem[a] = 8'd0;
        repeat (2) @(negedge CLK);
        chk_quiet("reset");
        RST_N = 1'b1;
        @(negedge CLK);

        fill(0, 1);
        run_scan(-1, 0, 0);
        fill(1, 0);
        run_scan(-1, 0, 0);
        fill(3, 255);
        run_scan(-1, 0, 0);
        fill(2, 3);
        run_scan(1, 10, 0);

        // Reset in the middle of the level 1 scan.
        fill(2, 3);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lvl.lvl_ready = 1'b1;
        repeat (75) @(negedge CLK);
        chk("mid_rd", rd_en, 1);
        RST_N = 1'b0;
        @(negedge CLK);
        chk_quiet("abort_rst");
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_no_done", done, 0);
        end
        run_scan(-1, 0, 0);

        // Builder owns memory: start is ignored.
        BC_mode = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            chk("mode_rd", rd_en, 0);
            chk("mode_busy", busy, 0);
        end
        BC_mode = 1'b0;
        @(negedge CLK);

        // Stray start while busy.
        fill(2, 3);
        run_scan(-1, 0, 3);

        // Builder takes memory back mid scan.
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (20) @(negedge CLK);
        BC_mode = 1'b1;
        @(negedge CLK);
        chk_quiet("abort_mode");
        BC_mode = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            chk("mode_no_done", done, 0);
        end

        repeat (4) begin
            fill(2, $urandom_range(0, 3));
            run_scan($urandom_range(0, 4), $urandom_range(1, 6), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
